// File: rtl/mac_pkg.sv
// Shared MAC definitions: transmit FSM states, CRC-32 constants and a
// byte-wide reflected CRC-32 update used by both the TX and RX sides.
package mac_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DATA,
    PAD,
    FCS,
    ABORT,
    DROP,
    IFG
  } tx_state_e;

  localparam logic [31:0] CRC32_POLY = 32'hEDB88320;
  localparam logic [31:0] CRC32_INIT = 32'hFFFFFFFF;

  // Width of the frame byte counter (holds up to 2047, enough for MAX_LEN)
  localparam int CNT_W = 11;

  // One byte of reflected CRC-32: fold the byte into the low bits, then
  // shift out eight bits LSB first.
  function automatic logic [31:0] crc32_byte(input logic [31:0] crc,
                                             input logic [7:0]  data);
    logic [31:0] c;
    c = crc ^ {24'h000000, data};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC32_POLY) : (c >> 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/mac_tx_fcs.sv
// CRC-32 accumulator for the transmit path. Clear has priority over update;
// the running value is exposed raw (not inverted) so the caller can send
// either the proper FCS (~crc) or a deliberately corrupted one (crc).
import mac_pkg::*;

module mac_tx_fcs (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        update,
  input  logic [7:0]  data,
  output logic [31:0] crc
);

  // Running CRC over every emitted data/pad byte
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crc <= CRC32_INIT;
    end else if (clear) begin
      crc <= CRC32_INIT;
    end else if (update) begin
      crc <= crc32_byte(crc, data);
    end
  end

endmodule

// File: rtl/mac_tx.sv
// Ethernet frame transmitter: accepts client payload on a valid/ready
// stream, zero-pads to MIN_LEN, appends the CRC-32 FCS and emits one byte
// per cycle with no gaps inside a frame. Underrun or oversize frames are
// terminated with an inverted FCS and an abort pulse, the rest of the
// client frame is discarded, and an inter-frame gap follows every frame.
import mac_pkg::*;

module mac_tx #(
  parameter int MIN_LEN    = 60,
  parameter int MAX_LEN    = 1514,
  parameter int IFG_CYCLES = 12
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       s_valid,
  output logic       s_ready,
  input  logic [7:0] s_data,
  input  logic       s_last,
  output logic       tx_valid,
  output logic [7:0] tx_data,
  output logic       tx_last,
  output logic       tx_abort,
  output logic       busy
);

  tx_state_e        state_reg;
  logic [CNT_W-1:0] count_reg;
  logic [CNT_W-1:0] count_next;
  logic [1:0]       idx_reg;
  logic [7:0]       ifg_reg;
  logic [31:0]      crc;
  logic [7:0]       fcs_byte;
  logic [7:0]       crc_data;
  logic             xfer;
  logic             crc_clear;
  logic             crc_update;

  // Client may push bytes only while a frame is being collected or dropped
  assign s_ready = (state_reg == IDLE) || (state_reg == DATA) || (state_reg == DROP);
  assign busy    = (state_reg != IDLE);
  assign xfer    = s_valid & s_ready;

  // Byte count after the current byte, saturating at MAX_LEN
  assign count_next = (count_reg == CNT_W'(MAX_LEN)) ? count_reg : count_reg + CNT_W'(1);

  // Raw CRC byte selected by the FCS byte index, LSB byte first
  assign fcs_byte = crc[{idx_reg, 3'b000} +: 8];

  // CRC covers payload and pad bytes; it restarts after each frame's 4th FCS byte
  assign crc_update = (xfer && ((state_reg == IDLE) || (state_reg == DATA))) || (state_reg == PAD);
  assign crc_data   = (state_reg == PAD) ? 8'h00 : s_data;
  assign crc_clear  = ((state_reg == FCS) || (state_reg == ABORT)) && (idx_reg == 2'd3);

  mac_tx_fcs u_fcs (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (crc_clear),
    .update (crc_update),
    .data   (crc_data),
    .crc    (crc)
  );

  // Frame sequencing with registered output stream
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      count_reg <= '0;
      idx_reg   <= 2'd0;
      ifg_reg   <= 8'd0;
      tx_valid  <= 1'b0;
      tx_data   <= 8'h00;
      tx_last   <= 1'b0;
      tx_abort  <= 1'b0;
    end else begin
      tx_valid <= 1'b0;
      tx_data  <= 8'h00;
      tx_last  <= 1'b0;
      tx_abort <= 1'b0;
      unique case (state_reg)
        IDLE, DATA: begin
          if (xfer) begin
            tx_valid  <= 1'b1;
            tx_data   <= s_data;
            count_reg <= count_next;
            idx_reg   <= 2'd0;
            if (s_last) begin
              state_reg <= (count_next < CNT_W'(MIN_LEN)) ? PAD : FCS;
            end else if (count_next == CNT_W'(MAX_LEN)) begin
              // The MAX_LEN-th byte without s_last is still emitted, then the frame is killed
              state_reg <= ABORT;
            end else begin
              state_reg <= DATA;
            end
          end else if (state_reg == DATA) begin
            // Underrun: the first corrupted FCS byte goes out now so tx_valid stays contiguous
            tx_valid  <= 1'b1;
            tx_data   <= fcs_byte;
            idx_reg   <= 2'd1;
            state_reg <= ABORT;
          end
        end
        PAD: begin
          tx_valid  <= 1'b1;
          tx_data   <= 8'h00;
          count_reg <= count_next;
          if (count_next >= CNT_W'(MIN_LEN)) begin
            idx_reg   <= 2'd0;
            state_reg <= FCS;
          end
        end
        FCS: begin
          tx_valid <= 1'b1;
          tx_data  <= ~fcs_byte;
          idx_reg  <= idx_reg + 2'd1;
          if (idx_reg == 2'd3) begin
            tx_last   <= 1'b1;
            count_reg <= '0;
            ifg_reg   <= 8'd0;
            state_reg <= IFG;
          end
        end
        ABORT: begin
          tx_valid <= 1'b1;
          tx_data  <= fcs_byte;
          idx_reg  <= idx_reg + 2'd1;
          if (idx_reg == 2'd3) begin
            // The aborting byte never carries s_last, so the remainder is always drained
            tx_last   <= 1'b1;
            tx_abort  <= 1'b1;
            count_reg <= '0;
            state_reg <= DROP;
          end
        end
        DROP: begin
          if (xfer && s_last) begin
            ifg_reg   <= 8'd0;
            state_reg <= IFG;
          end
        end
        IFG: begin
          if (ifg_reg == 8'(IFG_CYCLES - 1)) begin
            state_reg <= IDLE;
          end else begin
            ifg_reg <= ifg_reg + 8'd1;
          end
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mac_tx.sv
// Bench for mac_tx: table of frames plus hand-written back-to-back and
// mid-frame reset sequences. Expected output bytes are queued when a frame
// is driven and popped as the DUT emits them; an RX-side CRC model checks
// the FCS residue of every good frame.
`timescale 1ns/1ps

module tb_mac_tx;

  localparam int MIN_LEN    = 60;
  localparam int MAX_LEN    = 1514;
  localparam int IFG_CYCLES = 12;
  localparam logic [31:0] RESIDUE = 32'hDEBB20E3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       s_valid = 1'b0;
  logic       s_last = 1'b0;
  logic [7:0] s_data = 8'h00;
  logic       s_ready;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_last;
  logic       tx_abort;
  logic       busy;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [7:0] data;
    logic       last;
    logic       abort;
  } exp_t;

  typedef struct packed {
    int   n;
    logic ab;
  } done_t;

  typedef struct {
    int len;
    int cut;
    bit ascii;
    int exp_tx;
    bit exp_abort;
  } vec_t;

  exp_t       exp_q[$];
  done_t      done_q[$];
  logic [7:0] payload_q[$];

  // RX-side monitor state
  bit          in_frame = 1'b0;
  bit          ifg_watch = 1'b0;
  int          nb = 0;
  int          gap = -1;
  logic [31:0] rx_crc = 32'hFFFFFFFF;

  mac_tx dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .s_data   (s_data),
    .s_last   (s_last),
    .tx_valid (tx_valid),
    .tx_data  (tx_data),
    .tx_last  (tx_last),
    .tx_abort (tx_abort),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  // Bitwise reference CRC: one input bit at a time
  function automatic logic [31:0] crc_upd(input logic [31:0] c_in, input logic [7:0] d);
    logic [31:0] c;
    logic        fb;
    c = c_in;
    for (int i = 0; i < 8; i++) begin
      fb = c[0] ^ d[i];
      c  = c >> 1;
      if (fb) c = c ^ 32'hEDB88320;
    end
    return c;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual %h required %h", name, act, req);
    end
  endtask

  // Output monitor: scoreboard pop, RX residue, contiguity and gap checks
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      in_frame  = 1'b0;
      ifg_watch = 1'b0;
      nb        = 0;
      gap       = -1;
      rx_crc    = 32'hFFFFFFFF;
    end else if (tx_valid) begin
      if (!in_frame) begin
        if (gap >= 0) check("ifg_gap", 32'((gap < IFG_CYCLES) ? gap : IFG_CYCLES), 32'(IFG_CYCLES));
        in_frame  = 1'b1;
        ifg_watch = 1'b0;
        nb        = 0;
        gap       = -1;
        rx_crc    = 32'hFFFFFFFF;
      end
      if (exp_q.size() == 0) begin
        check("unexpected_byte", 32'(tx_data), 32'hFFFFFFFF);
      end else begin
        e = exp_q.pop_front();
        check("tx_data", 32'(tx_data), 32'(e.data));
        check("tx_last", 32'(tx_last), 32'(e.last));
        check("tx_abort", 32'(tx_abort), 32'(e.abort));
      end
      nb++;
      rx_crc = crc_upd(rx_crc, tx_data);
      if (tx_last) begin
        if (!tx_abort) check("fcs_residue", rx_crc, RESIDUE);
        else           check("abort_residue_is_good", 32'(rx_crc == RESIDUE), 32'd0);
        // Good frame sits in IFG (not ready); aborted frame is already draining (ready)
        check("ready_at_last", 32'(s_ready), 32'(tx_abort));
        done_q.push_back('{n: nb, ab: tx_abort});
        in_frame  = 1'b0;
        ifg_watch = !tx_abort;
        gap       = 0;
      end
    end else begin
      if (in_frame) check("tx_valid_contiguous", 32'(tx_valid), 32'd1);
      if (gap >= 0) gap++;
      if (ifg_watch && gap >= 1 && gap < IFG_CYCLES) begin
        check("ifg_ready", 32'(s_ready), 32'd0);
        check("ifg_busy", 32'(busy), 32'd1);
      end
      if (ifg_watch && gap == IFG_CYCLES) begin
        check("ifg_end_busy", 32'(busy), 32'd0);
        ifg_watch = 1'b0;
      end
    end
  end

  task automatic build_payload(input int len, input bit ascii);
    payload_q.delete();
    for (int i = 0; i < len; i++) begin
      if (ascii) payload_q.push_back(8'(32'h31 + i));
      else       payload_q.push_back(8'($urandom));
    end
  endtask

  // Expected wire bytes for a frame: data (truncated on abort), pad, FCS
  task automatic push_frame(input int len, input int cut);
    logic [31:0] c;
    logic [31:0] fcs;
    exp_t        e;
    int          n;
    bit          ab;
    ab = (cut > 0) || (len > MAX_LEN);
    n  = (cut > 0) ? cut : ((len > MAX_LEN) ? MAX_LEN : len);
    c  = 32'hFFFFFFFF;
    for (int i = 0; i < n; i++) begin
      e.data = payload_q[i]; e.last = 1'b0; e.abort = 1'b0;
      exp_q.push_back(e);
      c = crc_upd(c, payload_q[i]);
    end
    if (!ab) begin
      for (int i = n; i < MIN_LEN; i++) begin
        e.data = 8'h00; e.last = 1'b0; e.abort = 1'b0;
        exp_q.push_back(e);
        c = crc_upd(c, 8'h00);
      end
    end
    fcs = ab ? c : ~c;
    for (int k = 0; k < 4; k++) begin
      e.data  = fcs[8*k +: 8];
      e.last  = (k == 3);
      e.abort = ab && (k == 3);
      exp_q.push_back(e);
    end
  endtask

  task automatic send(input logic [7:0] d, input logic last);
    int guard;
    guard = 0;
    @(negedge clk);
    s_valid = 1'b1;
    s_data  = d;
    s_last  = last;
    while (!s_ready && guard < 5000) begin
      @(negedge clk);
      guard++;
    end
    if (!s_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout actual s_ready=0 required s_ready=1");
    end
  endtask

  task automatic drive_frame(input int len, input int cut);
    for (int i = 0; i < len; i++) begin
      if (cut > 0 && i == cut) begin
        @(negedge clk);
        s_valid = 1'b0;
        s_last  = 1'b0;
      end
      send(payload_q[i], i == len - 1);
    end
  endtask

  task automatic end_frame();
    @(negedge clk);
    s_valid = 1'b0;
    s_last  = 1'b0;
    s_data  = 8'h00;
  endtask

  task automatic wait_done(output int n, output bit ab);
    done_t d;
    int    cyc;
    cyc = 0;
    n   = -1;
    ab  = 1'b0;
    while (done_q.size() == 0 && cyc < 5000) begin
      @(posedge clk);
      cyc++;
    end
    if (done_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL frame_timeout actual no tx_last required tx_last within 5000 cycles");
    end else begin
      d  = done_q.pop_front();
      n  = d.n;
      ab = d.ab;
    end
  endtask

  task automatic check_frame(input string tag, input int exp_n, input bit exp_ab);
    int n;
    bit ab;
    wait_done(n, ab);
    check({tag, "_bytes"}, 32'(n), 32'(exp_n));
    check({tag, "_abort"}, 32'(ab), 32'(exp_ab));
    $display("frame %s tx_bytes %0d abort %0d", tag, n, ab);
  endtask

  vec_t vecs[9];

  initial begin
    // len, underrun-after, ascii payload, expected tx bytes, expected abort
    vecs[0] = '{len: 9,    cut: 0,  ascii: 1'b1, exp_tx: 64,   exp_abort: 1'b0};
    vecs[1] = '{len: 60,   cut: 0,  ascii: 1'b0, exp_tx: 64,   exp_abort: 1'b0};
    vecs[2] = '{len: 61,   cut: 0,  ascii: 1'b0, exp_tx: 65,   exp_abort: 1'b0};
    vecs[3] = '{len: 1,    cut: 0,  ascii: 1'b0, exp_tx: 64,   exp_abort: 1'b0};
    vecs[4] = '{len: 10,   cut: 3,  ascii: 1'b0, exp_tx: 7,    exp_abort: 1'b1};
    vecs[5] = '{len: 59,   cut: 0,  ascii: 1'b0, exp_tx: 64,   exp_abort: 1'b0};
    vecs[6] = '{len: 1514, cut: 0,  ascii: 1'b0, exp_tx: 1518, exp_abort: 1'b0};
    vecs[7] = '{len: 1516, cut: 0,  ascii: 1'b0, exp_tx: 1518, exp_abort: 1'b1};
    vecs[8] = '{len: 100,  cut: 50, ascii: 1'b0, exp_tx: 54,   exp_abort: 1'b1};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_s_ready", 32'(s_ready), 32'd1);
    check("rst_tx_valid", 32'(tx_valid), 32'd0);
    check("rst_tx_data", 32'(tx_data), 32'd0);
    check("rst_tx_last", 32'(tx_last), 32'd0);
    check("rst_tx_abort", 32'(tx_abort), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    @(posedge clk);
    #2 rst_n = 1'b1;

    // Table-driven frames
    for (int v = 0; v < 9; v++) begin
      build_payload(vecs[v].len, vecs[v].ascii);
      push_frame(vecs[v].len, vecs[v].cut);
      drive_frame(vecs[v].len, vecs[v].cut);
      end_frame();
      check_frame($sformatf("vec%0d_len%0d", v, vecs[v].len), vecs[v].exp_tx, vecs[v].exp_abort);
      check("sb_empty", 32'(exp_q.size()), 32'd0);
    end

    // Back-to-back frames with s_valid held high across the boundary
    build_payload(20, 1'b0);
    push_frame(20, 0);
    drive_frame(20, 0);
    build_payload(70, 1'b0);
    push_frame(70, 0);
    drive_frame(70, 0);
    end_frame();
    check_frame("b2b_a", 64, 1'b0);
    check_frame("b2b_b", 74, 1'b0);
    check("b2b_sb_empty", 32'(exp_q.size()), 32'd0);

    // Asynchronous reset in the middle of DATA
    build_payload(30, 1'b0);
    push_frame(30, 0);
    for (int i = 0; i < 10; i++) send(payload_q[i], 1'b0);
    @(posedge clk);
    #2;
    check("pre_reset_tx_valid", 32'(tx_valid), 32'd1);
    rst_n   = 1'b0;
    s_valid = 1'b0;
    #1;
    check("midrst_tx_valid", 32'(tx_valid), 32'd0);
    check("midrst_tx_data", 32'(tx_data), 32'd0);
    check("midrst_tx_last", 32'(tx_last), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_s_ready", 32'(s_ready), 32'd1);
    exp_q.delete();
    done_q.delete();
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    build_payload(12, 1'b0);
    push_frame(12, 0);
    drive_frame(12, 0);
    end_frame();
    check_frame("after_reset", 64, 1'b0);
    check("after_reset_sb_empty", 32'(exp_q.size()), 32'd0);

    repeat (5) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
